median_window_feeder: RTL and testbench
=======================================

Name: median_window_feeder

Overview:
- Initiator side of the MED serial-median protocol (DI/DSI in, DO/DSO out).
- Accepts a raster pixel stream and keeps two line buffers to build 3x3 neighbourhoods.
- For each complete window it drives 9 pixels serially on DI with DSI high, waits for DSO, captures DO and emits the median with a valid/ready handshake.
- Sits between the pixel source (camera/RAM reader) and the median filter datapath.

Parameters:
- WIDTH, 8, pixel bit width (same as the median unit).
- N_PIXELS, 9, window size; only 9 is legal, any other value is an elaboration error.
- IMG_W, 640, pixels per line; must be >= 3.
- IMG_H, 480, lines per frame; must be >= 3.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- PIX_IN  in  WIDTH  raster pixel, row-major order.
- PIX_VALID  in  1  PIX_IN valid.
- PIX_READY  out  1  feeder accepts PIX_IN; a transfer occurs when PIX_VALID and PIX_READY are both high.
- DI  out  WIDTH  serial window pixel to the median unit.
- DSI  out  1  window strobe; high for exactly 9 consecutive cycles per window.
- DO  in  WIDTH  median result from the median unit.
- DSO  in  1  DO valid, single-cycle pulse.
- RES  out  WIDTH  median output pixel.
- RES_VALID  out  1  RES valid.
- RES_READY  in  1  downstream accepts RES.
- FRAME_DONE  out  1  one-cycle pulse on the RES transfer of the last window in a frame.

Behaviour:
- Reset:
  - With RST high at a clock edge, state <= ACCEPT; row/col/feed counters <= 0; DI, RES <= 0; DSI, RES_VALID, FRAME_DONE <= 0.
  - PIX_READY is forced 0 while RST is high.
  - Line buffers and window registers are not reset; they are never read before being written in the current frame.
  - Reset mid-operation aborts everything immediately. DSI drops the next cycle, even mid-window; any pending RES is discarded.
- FSM states: ACCEPT, FEED, WAIT, OUT. PIX_READY = (state == ACCEPT) && !RST.
- ACCEPT, on a pixel transfer at (row r, col c):
  - Shift the window left by one column. New right column = {top_lb[c], mid_lb[c], PIX_IN}.
  - Update the line buffers: top_lb[c] <= mid_lb[c], mid_lb[c] <= PIX_IN.
  - Advance col. At col == IMG_W-1, wrap col to 0 and advance row. At row == IMG_H-1, also wrap row to 0.
  - If r >= 2 and c >= 2, go to FEED; otherwise stay in ACCEPT.
- FEED:
  - Lasts 9 cycles, starting the cycle after the transfer. DSI = 1 throughout.
  - DI order is w[0]..w[8], row-major: top-left, top-mid, top-right, mid-left, ..., bottom-right (bottom-right = PIX_IN just accepted).
  - DI and DSI are registered outputs. After the 9th cycle DSI = 0 and the FSM goes to WAIT.
- WAIT:
  - On DSO = 1, capture DO into RES, set RES_VALID = 1 the next cycle and go to OUT.
  - No timeout: WAIT holds until DSO or reset.
  - A DSO received in ACCEPT, FEED or OUT is ignored.
- OUT:
  - RES and RES_VALID are held stable until RES_READY.
  - On the transfer cycle, RES_VALID drops the next cycle and the FSM returns to ACCEPT.
  - FRAME_DONE pulses on the same cycle as the transfer, but only if the window came from pixel (IMG_H-1, IMG_W-1).
- Output count: exactly (IMG_W-2)*(IMG_H-2) results per frame. Border pixels produce no output.
- Throughput: at most one input per (1 + 9 + DSO latency + 1 + RES stall) cycles in the interior. During border rows/columns, input is one pixel per cycle.
- Latency: the first DSI is the cycle after the transfer. RES_VALID rises the cycle after DSO.
- Frame wrap: counters roll over seamlessly; the first two rows of the next frame produce no windows.

Decomposition:
- Package median_pkg holds:
  - feeder_state_t enum {ACCEPT, FEED, WAIT, OUT};
  - localparam N_WIN = 9;
  - col/row counter widths $clog2(IMG_W) and $clog2(IMG_H), via a width function;
  - assertion that N_PIXELS == N_WIN.
- Sub-module median_line_buffer: a two-row read/shift/write array.
  - Ports: CLK, addr, wr_en, din; outputs top, mid.
  - Combinational read; write on wr_en.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0..15 streamed back-to-back; median model returns DO = w[4] with DSO 3 cycles after DSI falls.
  - No DSI during pixels 0..9.
  - Pixel 10 transfer produces DI = 0,1,2,4,5,6,8,9,10.
  - Results RES = 5, 6, 9, 10; FRAME_DONE high only with RES = 10.
- DSI framing: for every window, DSI is high exactly 9 cycles and PIX_READY = 0 from the transfer until the RES transfer completes.
- Back-pressure: hold RES_READY = 0 for 20 cycles in OUT -> RES/RES_VALID stable, no PIX_READY, no new DSI; release -> exactly one transfer.
- Spurious DSO = 1 during FEED and ACCEPT with DO = 8'hFF -> ignored; RES equals the value on the true DSO in WAIT.
- Assert RST at the 5th FEED cycle -> DSI = 0 next cycle, RES_VALID = 0, row/col = 0; resending a full frame reproduces the golden results.
- Two consecutive frames of random 8-bit pixels against a software 3x3 median model -> 4 matches per frame, one FRAME_DONE per frame.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and helpers for the median window feeder.
package median_pkg;

  // Feeder control states: take pixels, stream a window, wait for the median, hand it on.
  typedef enum logic [1:0] {
    ACCEPT,
    FEED,
    WAIT,
    OUT
  } feeder_state_t;

  // Pixels per 3x3 neighbourhood.
  localparam int N_WIN = 9;

  // Counter width for a range of n values (at least one bit).
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The feeder only knows how to build 3x3 windows.
  function automatic bit winSizeOk(input int n);
    return n == N_WIN;
  endfunction

endpackage

// File: rtl/median_line_buffer.sv
// Two-row line store: 'top' holds the row two lines up, 'mid' the row just above.
// Reads are combinational; a write shifts mid into top and stores din into mid.
module median_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic             CLK,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] mid
);

  logic [WIDTH-1:0] topMem_q [DEPTH];
  logic [WIDTH-1:0] midMem_q [DEPTH];

  assign top = topMem_q[addr];
  assign mid = midMem_q[addr];

  // Shift the column down one row on every accepted pixel; contents are never reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      topMem_q[addr] <= midMem_q[addr];
      midMem_q[addr] <= din;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Builds 3x3 neighbourhoods from a raster stream, streams each one serially to the
// median unit (DI/DSI), collects the answer (DO/DSO) and offers it on RES/RES_VALID.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_PIXELS = 9,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VALID,
  output logic             PIX_READY,
  output logic [WIDTH-1:0] DI,
  output logic             DSI,
  input  logic [WIDTH-1:0] DO,
  input  logic             DSO,
  output logic [WIDTH-1:0] RES,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             FRAME_DONE
);

  localparam int CW = cntWidth(IMG_W);
  localparam int RW = cntWidth(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [3:0]    FEED_LAST = 4'(N_WIN);

  if (!winSizeOk(N_PIXELS)) begin : gBadWindow
    $error("median_window_feeder: N_PIXELS must be 9");
  end
  if (IMG_W < 3 || IMG_H < 3) begin : gBadImage
    $error("median_window_feeder: IMG_W and IMG_H must be at least 3");
  end

  feeder_state_t    state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [3:0]       feedCnt_q, feedCnt_d;
  logic [WIDTH-1:0] di_q, di_d;
  logic             dsi_q, dsi_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             resValid_q, resValid_d;
  logic             lastWin_q, lastWin_d;

  logic [WIDTH-1:0] win_q   [N_WIN];
  logic [WIDTH-1:0] winNext [N_WIN];
  logic [WIDTH-1:0] lbTop, lbMid;
  logic             pixXfer;

  assign PIX_READY  = (state_q == ACCEPT) && !RST;
  assign pixXfer    = PIX_VALID && PIX_READY;
  assign DI         = di_q;
  assign DSI        = dsi_q;
  assign RES        = res_q;
  assign RES_VALID  = resValid_q;
  assign FRAME_DONE = resValid_q && RES_READY && lastWin_q && !RST;

  median_line_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) uLineBuf (
    .CLK   (CLK),
    .addr  (col_q),
    .wr_en (pixXfer),
    .din   (PIX_IN),
    .top   (lbTop),
    .mid   (lbMid)
  );

  // Window slides left by one column; the new right column comes from the line buffers and the input.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      winNext[3*i]     = win_q[3*i + 1];
      winNext[3*i + 1] = win_q[3*i + 2];
    end
    winNext[2] = lbTop;
    winNext[5] = lbMid;
    winNext[8] = PIX_IN;
  end

  // Window registers load on every accepted pixel; stale contents are flushed before use.
  always_ff @(posedge CLK) begin
    if (pixXfer) begin
      win_q <= winNext;
    end
  end

  // Next-state logic: raster counters, serial feed sequencing and result hand-off.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    feedCnt_d  = feedCnt_q;
    di_d       = di_q;
    dsi_d      = dsi_q;
    res_d      = res_q;
    resValid_d = resValid_q;
    lastWin_d  = lastWin_q;
    case (state_q)
      ACCEPT: begin
        if (pixXfer) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (row_q >= RW'(2) && col_q >= CW'(2)) begin
            state_d   = FEED;
            dsi_d     = 1'b1;
            di_d      = winNext[0];
            feedCnt_d = 4'd1;
            lastWin_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
          end
        end
      end
      FEED: begin
        if (feedCnt_q == FEED_LAST) begin
          dsi_d   = 1'b0;
          di_d    = '0;
          state_d = WAIT;
        end else begin
          di_d      = win_q[feedCnt_q];
          feedCnt_d = feedCnt_q + 4'd1;
        end
      end
      WAIT: begin
        if (DSO) begin
          res_d      = DO;
          resValid_d = 1'b1;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (RES_READY) begin
          resValid_d = 1'b0;
          state_d    = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  // Control and output registers; reset abandons any window or result in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ACCEPT;
      col_q      <= '0;
      row_q      <= '0;
      feedCnt_q  <= '0;
      di_q       <= '0;
      dsi_q      <= 1'b0;
      res_q      <= '0;
      resValid_q <= 1'b0;
      lastWin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      feedCnt_q  <= feedCnt_d;
      di_q       <= di_d;
      dsi_q      <= dsi_d;
      res_q      <= res_d;
      resValid_q <= resValid_d;
      lastWin_q  <= lastWin_d;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for the median window feeder on a 4x4 image with a behavioural median unit.
module tb_median_window_feeder;

  localparam int IW = 4;
  localparam int IH = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] PIX_IN;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic [7:0] DI;
  logic       DSI;
  logic [7:0] DO;
  logic       DSO;
  logic [7:0] RES;
  logic       RES_VALID;
  logic       RES_READY;
  logic       FRAME_DONE;

  logic       dsoModel = 1'b0;
  logic       dsoForce = 1'b0;
  logic [7:0] doModel  = 8'h00;

  int total = 0;
  int bad   = 0;
  int medMode = 0;
  logic busy = 1'b0;
  int resCount = 0;
  int frameDoneCount = 0;
  int mRow = 0;
  int mCol = 0;
  int cd = 0;
  bit firstWinSaved = 1'b0;

  logic [7:0] img [IH][IW];
  logic [7:0] rx[$];
  logic [7:0] firstWin[$];
  logic [7:0] expWinQ[$];
  logic [7:0] expResQ[$];
  logic       expLastQ[$];
  logic [7:0] resLog[$];

  logic [7:0] goldenWin [9] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
  logic [7:0] goldenRes [4] = '{8'd5, 8'd6, 8'd9, 8'd10};

  assign DSO = dsoModel | dsoForce;
  assign DO  = dsoForce ? 8'hFF : doModel;

  median_window_feeder #(
    .WIDTH    (8),
    .N_PIXELS (9),
    .IMG_W    (IW),
    .IMG_H    (IH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PIX_IN     (PIX_IN),
    .PIX_VALID  (PIX_VALID),
    .PIX_READY  (PIX_READY),
    .DI         (DI),
    .DSI        (DSI),
    .DO         (DO),
    .DSO        (DSO),
    .RES        (RES),
    .RES_VALID  (RES_VALID),
    .RES_READY  (RES_READY),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Median of a window: mode 0 answers with the centre pixel, mode 1 with the true median.
  function automatic logic [7:0] winResult(input logic [7:0] w [9], input int mode);
    logic [7:0] s [9];
    logic [7:0] t;
    if (mode == 0) return w[4];
    s = w;
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (s[j] > s[j+1]) begin
          t = s[j];
          s[j] = s[j+1];
          s[j+1] = t;
        end
      end
    end
    return s[4];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one pixel and hold it until the feeder takes it.
  task automatic applyStimulus(input logic [7:0] p);
    int n;
    n = 0;
    PIX_IN = p;
    PIX_VALID = 1'b1;
    @(negedge CLK);
    while (PIX_READY !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("pixAccepted", PIX_READY, 1);
    @(posedge CLK); #2;
    PIX_VALID = 1'b0;
  endtask

  // Let the last window of a frame run through to its result transfer.
  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge CLK);
    while ((busy || RES_VALID === 1'b1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("drained", busy, 0);
    @(posedge CLK); #2;
  endtask

  // Compare a directed 0..15 frame against the hand-computed centre values.
  task automatic checkGolden(input int fd0);
    checkOutput("goldenCount", resLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < resLog.size()) checkOutput($sformatf("goldenRes%0d", i), resLog[i], goldenRes[i]);
    end
    checkOutput("frameDoneCount", frameDoneCount - fd0, 1);
  endtask

  // Median unit model plus scoreboard: image array model of the raster, expected windows and results.
  always @(negedge CLK) begin
    logic [7:0] w [9];
    checkOutput("pixReady", PIX_READY, (!busy && !RST));
    if (!busy) checkOutput("dsiIdle", DSI, 0);
    dsoModel = 1'b0;
    if (RST === 1'b1) begin
      busy = 1'b0;
      rx.delete();
      expWinQ.delete();
      expResQ.delete();
      expLastQ.delete();
      cd = 0;
      mRow = 0;
      mCol = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) dsoModel = 1'b1;
      end
      if (DSI === 1'b1) begin
        rx.push_back(DI);
      end else if (rx.size() > 0) begin
        checkOutput("dsiLen", rx.size(), 9);
        for (int i = 0; i < 9; i++) w[i] = (i < rx.size()) ? rx[i] : 8'h00;
        if (!firstWinSaved) begin
          firstWin = rx;
          firstWinSaved = 1'b1;
        end
        checkOutput("winQueued", expWinQ.size(), 9);
        for (int i = 0; i < 9; i++) begin
          if (expWinQ.size() > 0) checkOutput($sformatf("winPix%0d", i), w[i], expWinQ.pop_front());
        end
        doModel = winResult(w, medMode);
        cd = 3;
        rx.delete();
      end
      if (RES_VALID === 1'b1 && RES_READY === 1'b1) begin
        resCount++;
        resLog.push_back(RES);
        checkOutput("resQueued", expResQ.size(), 1);
        if (expResQ.size() > 0) begin
          checkOutput("res", RES, expResQ.pop_front());
          checkOutput("frameDone", FRAME_DONE, expLastQ.pop_front());
        end
        if (FRAME_DONE === 1'b1) frameDoneCount++;
        busy = 1'b0;
      end else begin
        checkOutput("frameDoneIdle", FRAME_DONE, 0);
      end
      if (PIX_VALID === 1'b1 && PIX_READY === 1'b1) begin
        img[mRow][mCol] = PIX_IN;
        if (mRow >= 2 && mCol >= 2) begin
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
              w[3*r + c] = img[mRow - 2 + r][mCol - 2 + c];
              expWinQ.push_back(w[3*r + c]);
            end
          end
          expResQ.push_back(winResult(w, medMode));
          expLastQ.push_back(mRow == IH - 1 && mCol == IW - 1);
          busy = 1'b1;
        end
        if (mCol == IW - 1) begin
          mCol = 0;
          mRow = (mRow == IH - 1) ? 0 : mRow + 1;
        end else begin
          mCol++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int fd0;
    int rc0;
    RST = 1'b1;
    PIX_VALID = 1'b0;
    PIX_IN = 8'h00;
    RES_READY = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rstDsi", DSI, 0);
    checkOutput("rstDi", DI, 0);
    checkOutput("rstResValid", RES_VALID, 0);
    checkOutput("rstRes", RES, 0);
    checkOutput("rstFrameDone", FRAME_DONE, 0);
    checkOutput("rstPixReady", PIX_READY, 0);
    @(posedge CLK); #2;
    RST = 1'b0;

    // Frame A: plain directed ramp
    $display("[TB] frame A: directed ramp");
    resLog.delete();
    fd0 = frameDoneCount;
    for (int p = 0; p < 16; p++) applyStimulus(8'(p));
    waitIdle();
    checkGolden(fd0);
    checkOutput("firstWinLen", firstWin.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < firstWin.size()) checkOutput($sformatf("firstWin%0d", i), firstWin[i], goldenWin[i]);
    end

    // Frame B: spurious DSO in ACCEPT and FEED, back-pressure on the first result
    $display("[TB] frame B: spurious DSO and back-pressure");
    resLog.delete();
    fd0 = frameDoneCount;
    dsoForce = 1'b1;
    @(posedge CLK); #2;
    dsoForce = 1'b0;
    for (int p = 0; p < 10; p++) applyStimulus(8'(p));
    RES_READY = 1'b0;
    applyStimulus(8'd10);
    n = 0;
    @(negedge CLK);
    while (RES_VALID !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("bpValid", RES_VALID, 1);
    rc0 = resCount;
    repeat (20) begin
      @(negedge CLK);
      checkOutput("bpHoldValid", RES_VALID, 1);
      checkOutput("bpHoldRes", RES, 5);
      checkOutput("bpNoDsi", DSI, 0);
    end
    @(posedge CLK); #2;
    RES_READY = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("bpOneXfer", resCount - rc0, 1);
    checkOutput("bpValidDrop", RES_VALID, 0);
    @(posedge CLK); #2;
    applyStimulus(8'd11);
    dsoForce = 1'b1;
    repeat (2) begin
      @(posedge CLK); #2;
    end
    dsoForce = 1'b0;
    for (int p = 12; p < 16; p++) applyStimulus(8'(p));
    waitIdle();
    checkGolden(fd0);

    // Frame C: reset in the 5th feed cycle of the first window
    $display("[TB] frame C: reset mid-window");
    for (int p = 0; p < 11; p++) applyStimulus(8'(p));
    repeat (4) begin
      @(posedge CLK); #2;
    end
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("dsiBeforeRst", DSI, 1);
    @(posedge CLK); #2;
    @(negedge CLK);
    checkOutput("rstMidDsi", DSI, 0);
    checkOutput("rstMidResValid", RES_VALID, 0);
    checkOutput("rstMidPixReady", PIX_READY, 0);
    @(posedge CLK); #2;
    RST = 1'b0;

    // Frame D: full frame after reset must start again at row 0, col 0
    $display("[TB] frame D: resend after reset");
    resLog.delete();
    fd0 = frameDoneCount;
    for (int p = 0; p < 16; p++) applyStimulus(8'(p));
    waitIdle();
    checkGolden(fd0);

    // Two consecutive random frames against a true 3x3 median
    medMode = 1;
    for (int f = 0; f < 2; f++) begin
      $display("[TB] random frame %0d", f);
      resLog.delete();
      fd0 = frameDoneCount;
      for (int p = 0; p < 16; p++) applyStimulus(8'($urandom_range(0, 255)));
      waitIdle();
      checkOutput("rndCount", resLog.size(), 4);
      checkOutput("rndFrameDone", frameDoneCount - fd0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
